// File: rtl/uart_rx_cmd_decoder_if.sv
// uart_rx_cmd_decoder_if
// Bundles the UART receiver side (byte, valid strobe, line error flags) and
// the system-core side (register-file and ALU strobes plus held fields) of
// the command decoder.
//   RX_P_DATA   received byte, meaningful only with RX_D_VLD
//   RX_D_VLD    one-cycle pulse per error-free byte
//   RX_PAR_ERR  parity error level
//   RX_STP_ERR  stop-bit error level
//   RF_WrEn     register write strobe
//   RF_RdEn     register read strobe
//   RF_Address  register address (held)
//   RF_WrData   register write data (held)
//   ALU_EN      ALU operation strobe
//   ALU_FUN     ALU function code (held)
//   FRM_ERR     frame-dropped pulse
//   BUSY        decoder is mid-frame
// master: the side feeding bytes in and observing commands (receiver/core).
// slave:  the decoder itself.
interface uart_rx_cmd_decoder_if #(
    parameter int ADDR_WIDTH = 4
) ();
    logic [7:0]            RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  RX_PAR_ERR;
    logic                  RX_STP_ERR;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [7:0]            RF_WrData;
    logic                  ALU_EN;
    logic [3:0]            ALU_FUN;
    logic                  FRM_ERR;
    logic                  BUSY;

    modport master (
        output RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  ALU_EN, ALU_FUN, FRM_ERR, BUSY
    );

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output ALU_EN, ALU_FUN, FRM_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_cmd_decoder.sv
// uart_rx_cmd_decoder
// Assembles multi-byte command frames from the UART receiver and issues
// single-cycle register-file write/read strobes and ALU enable strobes.
// Frames hit by line errors, unknown opcodes or inter-byte timeouts are
// dropped and flagged with a one-cycle FRM_ERR.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-low reset
//   bus  uart_rx_cmd_decoder_if.slave (receiver inputs, core-side outputs)
// Parameters:
//   ADDR_WIDTH   register-file address width (at most 8)
//   TIMEOUT_CYC  idle cycles tolerated between bytes of a frame; 0 disables
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for an opcode byte
// WR_ADDR | write frame, waiting for address
// WR_DATA | write frame, waiting for data
// RD_ADDR | read frame, waiting for address
// OP_A    | ALU frame, waiting for operand A (written to reg 0)
// OP_B    | ALU frame, waiting for operand B (written to reg 1)
// FUN_OP  | ALU frame with operands, waiting for function code
// FUN_NOP | ALU frame without operands, waiting for function code
module uart_rx_cmd_decoder #(
    parameter int          ADDR_WIDTH  = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_cmd_decoder_if.slave  bus
);

    localparam logic [7:0] OPC_WR     = 8'hAA;
    localparam logic [7:0] OPC_RD     = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO = 8'hDD;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        OP_A    = 3'd4,
        OP_B    = 3'd5,
        FUN_OP  = 3'd6,
        FUN_NOP = 3'd7
    } state_t;

    state_t      state;
    logic [15:0] idle_cnt;
    logic        line_err;

    assign line_err = bus.RX_PAR_ERR | bus.RX_STP_ERR;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= IDLE;
            idle_cnt       <= '0;
            bus.RF_WrEn    <= 1'b0;
            bus.RF_RdEn    <= 1'b0;
            bus.RF_Address <= '0;
            bus.RF_WrData  <= '0;
            bus.ALU_EN     <= 1'b0;
            bus.ALU_FUN    <= '0;
            bus.FRM_ERR    <= 1'b0;
            bus.BUSY       <= 1'b0;
        end else begin
            bus.RF_WrEn <= 1'b0;
            bus.RF_RdEn <= 1'b0;
            bus.ALU_EN  <= 1'b0;
            bus.FRM_ERR <= 1'b0;

            if (state == IDLE) begin
                idle_cnt <= '0;
                // A byte arriving with a line error is discarded silently.
                if (bus.RX_D_VLD && !line_err) begin
                    case (bus.RX_P_DATA)
                        OPC_WR:     begin state <= WR_ADDR; bus.BUSY <= 1'b1; end
                        OPC_RD:     begin state <= RD_ADDR; bus.BUSY <= 1'b1; end
                        OPC_ALU_OP: begin state <= OP_A;    bus.BUSY <= 1'b1; end
                        OPC_ALU_NO: begin state <= FUN_NOP; bus.BUSY <= 1'b1; end
                        default:    bus.FRM_ERR <= 1'b1;
                    endcase
                end
            end else if (line_err) begin
                // Error outranks a coincident byte; earlier operand writes stand.
                state       <= IDLE;
                idle_cnt    <= '0;
                bus.FRM_ERR <= 1'b1;
                bus.BUSY    <= 1'b0;
            end else if (bus.RX_D_VLD) begin
                // A byte in the would-be timeout cycle is still accepted.
                idle_cnt <= '0;
                case (state)
                    WR_ADDR: begin
                        bus.RF_Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state          <= WR_DATA;
                    end
                    WR_DATA: begin
                        bus.RF_WrData <= bus.RX_P_DATA;
                        bus.RF_WrEn   <= 1'b1;
                        state         <= IDLE;
                        bus.BUSY      <= 1'b0;
                    end
                    RD_ADDR: begin
                        bus.RF_Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        bus.RF_RdEn    <= 1'b1;
                        state          <= IDLE;
                        bus.BUSY       <= 1'b0;
                    end
                    OP_A: begin
                        bus.RF_Address <= '0;
                        bus.RF_WrData  <= bus.RX_P_DATA;
                        bus.RF_WrEn    <= 1'b1;
                        state          <= OP_B;
                    end
                    OP_B: begin
                        bus.RF_Address <= ADDR_WIDTH'(1);
                        bus.RF_WrData  <= bus.RX_P_DATA;
                        bus.RF_WrEn    <= 1'b1;
                        state          <= FUN_OP;
                    end
                    FUN_OP, FUN_NOP: begin
                        bus.ALU_FUN <= bus.RX_P_DATA[3:0];
                        bus.ALU_EN  <= 1'b1;
                        state       <= IDLE;
                        bus.BUSY    <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end
                endcase
            end else if ((TIMEOUT_CYC != 16'd0) && (idle_cnt == TIMEOUT_CYC - 16'd1)) begin
                state       <= IDLE;
                idle_cnt    <= '0;
                bus.FRM_ERR <= 1'b1;
                bus.BUSY    <= 1'b0;
            end else if (idle_cnt != 16'hFFFF) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed testbench for uart_rx_cmd_decoder (ADDR_WIDTH=4, TIMEOUT_CYC=8).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_uart_rx_cmd_decoder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    uart_rx_cmd_decoder_if #(.ADDR_WIDTH(4)) bus ();

    uart_rx_cmd_decoder #(
        .ADDR_WIDTH  (4),
        .TIMEOUT_CYC (16'd8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.RX_P_DATA  = 8'h00;
        bus.RX_D_VLD   = 1'b0;
        bus.RX_PAR_ERR = 1'b0;
        bus.RX_STP_ERR = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.RF_WrEn !== 1'b0)    begin n_err++; $display("FAIL reset_wren got %b want 0", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_RdEn !== 1'b0)    begin n_err++; $display("FAIL reset_rden got %b want 0", bus.RF_RdEn); end
        n_cmp++; if (bus.RF_Address !== 4'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrData !== 8'h00) begin n_err++; $display("FAIL reset_wrdata got %h want 00", bus.RF_WrData); end
        n_cmp++; if (bus.ALU_EN !== 1'b0)     begin n_err++; $display("FAIL reset_aluen got %b want 0", bus.ALU_EN); end
        n_cmp++; if (bus.ALU_FUN !== 4'h0)    begin n_err++; $display("FAIL reset_alufun got %h want 0", bus.ALU_FUN); end
        n_cmp++; if (bus.FRM_ERR !== 1'b0)    begin n_err++; $display("FAIL reset_frmerr got %b want 0", bus.FRM_ERR); end
        n_cmp++; if (bus.BUSY !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write();
        send_byte(8'hAA);
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL wr_busy_rise got %b want 1", bus.BUSY); end
        send_byte(8'h05);
        n_cmp++; if (bus.RF_WrEn !== 1'b0) begin n_err++; $display("FAIL wr_early_wren got %b want 0", bus.RF_WrEn); end
        send_byte(8'h3C);
        n_cmp++; if (bus.RF_WrEn !== 1'b1)    begin n_err++; $display("FAIL wr_wren got %b want 1", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_Address !== 4'h5) begin n_err++; $display("FAIL wr_addr got %h want 5", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrData !== 8'h3C) begin n_err++; $display("FAIL wr_data got %h want 3c", bus.RF_WrData); end
        n_cmp++; if (bus.BUSY !== 1'b0)       begin n_err++; $display("FAIL wr_busy_fall got %b want 0", bus.BUSY); end
        tick();
        n_cmp++; if (bus.RF_WrEn !== 1'b0)    begin n_err++; $display("FAIL wr_pulse_width got %b want 0", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_WrData !== 8'h3C) begin n_err++; $display("FAIL wr_data_hold got %h want 3c", bus.RF_WrData); end
    endtask

    task automatic test_read_alu();
        send_byte(8'hBB);
        send_byte(8'h0F);
        n_cmp++; if (bus.RF_RdEn !== 1'b1)    begin n_err++; $display("FAIL rd_rden got %b want 1", bus.RF_RdEn); end
        n_cmp++; if (bus.RF_Address !== 4'hF) begin n_err++; $display("FAIL rd_addr got %h want f", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrEn !== 1'b0)    begin n_err++; $display("FAIL rd_wren got %b want 0", bus.RF_WrEn); end
        send_byte(8'hDD);
        n_cmp++; if (bus.RF_RdEn !== 1'b0) begin n_err++; $display("FAIL rd_pulse_width got %b want 0", bus.RF_RdEn); end
        n_cmp++; if (bus.BUSY !== 1'b1)    begin n_err++; $display("FAIL nop_busy got %b want 1", bus.BUSY); end
        send_byte(8'h1A);
        n_cmp++; if (bus.ALU_EN !== 1'b1)  begin n_err++; $display("FAIL nop_aluen got %b want 1", bus.ALU_EN); end
        n_cmp++; if (bus.ALU_FUN !== 4'hA) begin n_err++; $display("FAIL nop_alufun got %h want a", bus.ALU_FUN); end
        n_cmp++; if (bus.BUSY !== 1'b0)    begin n_err++; $display("FAIL nop_busy_fall got %b want 0", bus.BUSY); end
    endtask

    task automatic test_alu_ops();
        send_byte(8'hCC);
        n_cmp++; if (bus.ALU_EN !== 1'b0) begin n_err++; $display("FAIL alu_aluen_clear got %b want 0", bus.ALU_EN); end
        send_byte(8'h11);
        n_cmp++; if (bus.RF_WrEn !== 1'b1)    begin n_err++; $display("FAIL alu_a_wren got %b want 1", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_Address !== 4'h0) begin n_err++; $display("FAIL alu_a_addr got %h want 0", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrData !== 8'h11) begin n_err++; $display("FAIL alu_a_data got %h want 11", bus.RF_WrData); end
        send_byte(8'h22);
        n_cmp++; if (bus.RF_WrEn !== 1'b1)    begin n_err++; $display("FAIL alu_b_wren got %b want 1", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_Address !== 4'h1) begin n_err++; $display("FAIL alu_b_addr got %h want 1", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrData !== 8'h22) begin n_err++; $display("FAIL alu_b_data got %h want 22", bus.RF_WrData); end
        n_cmp++; if (bus.ALU_EN !== 1'b0)     begin n_err++; $display("FAIL alu_b_aluen got %b want 0", bus.ALU_EN); end
        send_byte(8'h03);
        n_cmp++; if (bus.ALU_EN !== 1'b1)  begin n_err++; $display("FAIL alu_en got %b want 1", bus.ALU_EN); end
        n_cmp++; if (bus.ALU_FUN !== 4'h3) begin n_err++; $display("FAIL alu_fun got %h want 3", bus.ALU_FUN); end
        n_cmp++; if (bus.RF_WrEn !== 1'b0) begin n_err++; $display("FAIL alu_fun_wren got %b want 0", bus.RF_WrEn); end
        n_cmp++; if (bus.BUSY !== 1'b0)    begin n_err++; $display("FAIL alu_busy_fall got %b want 0", bus.BUSY); end
    endtask

    task automatic test_abort();
        send_byte(8'hAA);
        send_byte(8'h02);
        bus.RX_PAR_ERR = 1'b1;
        tick();
        bus.RX_PAR_ERR = 1'b0;
        n_cmp++; if (bus.FRM_ERR !== 1'b1) begin n_err++; $display("FAIL abort_frmerr got %b want 1", bus.FRM_ERR); end
        n_cmp++; if (bus.RF_WrEn !== 1'b0) begin n_err++; $display("FAIL abort_wren got %b want 0", bus.RF_WrEn); end
        n_cmp++; if (bus.BUSY !== 1'b0)    begin n_err++; $display("FAIL abort_busy got %b want 0", bus.BUSY); end
        tick();
        n_cmp++; if (bus.FRM_ERR !== 1'b0) begin n_err++; $display("FAIL abort_pulse_width got %b want 0", bus.FRM_ERR); end
        send_byte(8'h55);
        n_cmp++; if (bus.FRM_ERR !== 1'b1) begin n_err++; $display("FAIL bad_opcode_frmerr got %b want 1", bus.FRM_ERR); end
        n_cmp++; if (bus.BUSY !== 1'b0)    begin n_err++; $display("FAIL bad_opcode_busy got %b want 0", bus.BUSY); end
        // Line error while idle is ignored.
        bus.RX_PAR_ERR = 1'b1;
        tick();
        bus.RX_PAR_ERR = 1'b0;
        n_cmp++; if (bus.FRM_ERR !== 1'b0) begin n_err++; $display("FAIL idle_err_frmerr got %b want 0", bus.FRM_ERR); end
        // A byte carrying a line error in IDLE is discarded: the next byte acts as opcode.
        bus.RX_STP_ERR = 1'b1;
        send_byte(8'hBB);
        bus.RX_STP_ERR = 1'b0;
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL idle_err_byte_busy got %b want 0", bus.BUSY); end
    endtask

    task automatic test_timeout();
        send_byte(8'hCC);
        send_byte(8'h44);
        n_cmp++; if (bus.RF_WrEn !== 1'b1)    begin n_err++; $display("FAIL to_a_wren got %b want 1", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_WrData !== 8'h44) begin n_err++; $display("FAIL to_a_data got %h want 44", bus.RF_WrData); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++; if (bus.FRM_ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
                n_err++; $display("FAIL to_early cycle %0d got frm_err=%b busy=%b want 0/1", k, bus.FRM_ERR, bus.BUSY);
            end
        end
        tick();
        n_cmp++; if (bus.FRM_ERR !== 1'b1) begin n_err++; $display("FAIL to_frmerr got %b want 1", bus.FRM_ERR); end
        n_cmp++; if (bus.BUSY !== 1'b0)    begin n_err++; $display("FAIL to_busy got %b want 0", bus.BUSY); end
        n_cmp++; if (bus.ALU_EN !== 1'b0)  begin n_err++; $display("FAIL to_aluen got %b want 0", bus.ALU_EN); end
    endtask

    task automatic test_byte_wins_timeout();
        send_byte(8'hCC);
        send_byte(8'h44);
        for (int k = 1; k <= 7; k++) tick();
        // Byte lands exactly in the cycle the timeout would fire.
        send_byte(8'h99);
        n_cmp++; if (bus.FRM_ERR !== 1'b0)    begin n_err++; $display("FAIL bw_frmerr got %b want 0", bus.FRM_ERR); end
        n_cmp++; if (bus.RF_WrEn !== 1'b1)    begin n_err++; $display("FAIL bw_wren got %b want 1", bus.RF_WrEn); end
        n_cmp++; if (bus.RF_Address !== 4'h1) begin n_err++; $display("FAIL bw_addr got %h want 1", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrData !== 8'h99) begin n_err++; $display("FAIL bw_data got %h want 99", bus.RF_WrData); end
        n_cmp++; if (bus.BUSY !== 1'b1)       begin n_err++; $display("FAIL bw_busy got %b want 1", bus.BUSY); end
        // Counter restarted: 7 more silent cycles must not time out.
        for (int k = 1; k <= 7; k++) tick();
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL bw_restart_busy got %b want 1", bus.BUSY); end
        send_byte(8'hF5);
        n_cmp++; if (bus.ALU_EN !== 1'b1)  begin n_err++; $display("FAIL bw_aluen got %b want 1", bus.ALU_EN); end
        n_cmp++; if (bus.ALU_FUN !== 4'h5) begin n_err++; $display("FAIL bw_alufun got %h want 5", bus.ALU_FUN); end
    endtask

    task automatic test_simultaneous();
        send_byte(8'hAA);
        send_byte(8'h07);
        bus.RX_STP_ERR = 1'b1;
        send_byte(8'h77);
        bus.RX_STP_ERR = 1'b0;
        n_cmp++; if (bus.RF_WrEn !== 1'b0)    begin n_err++; $display("FAIL sim_wren got %b want 0", bus.RF_WrEn); end
        n_cmp++; if (bus.FRM_ERR !== 1'b1)    begin n_err++; $display("FAIL sim_frmerr got %b want 1", bus.FRM_ERR); end
        n_cmp++; if (bus.RF_WrData !== 8'h99) begin n_err++; $display("FAIL sim_data_hold got %h want 99", bus.RF_WrData); end
        n_cmp++; if (bus.BUSY !== 1'b0)       begin n_err++; $display("FAIL sim_busy got %b want 0", bus.BUSY); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hAA);
        send_byte(8'h09);
        n_cmp++; if (bus.RF_Address !== 4'h9) begin n_err++; $display("FAIL rm_addr_pre got %h want 9", bus.RF_Address); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.RF_Address !== 4'h0) begin n_err++; $display("FAIL rm_addr got %h want 0", bus.RF_Address); end
        n_cmp++; if (bus.RF_WrData !== 8'h00) begin n_err++; $display("FAIL rm_data got %h want 00", bus.RF_WrData); end
        n_cmp++; if (bus.ALU_FUN !== 4'h0)    begin n_err++; $display("FAIL rm_alufun got %h want 0", bus.ALU_FUN); end
        n_cmp++; if (bus.BUSY !== 1'b0)       begin n_err++; $display("FAIL rm_busy got %b want 0", bus.BUSY); end
        tick();
        rst = 1'b1;
        tick();
        // Partial frame gone: 0x3C after reset is an unknown opcode.
        send_byte(8'h3C);
        n_cmp++; if (bus.FRM_ERR !== 1'b1) begin n_err++; $display("FAIL rm_discard_frmerr got %b want 1", bus.FRM_ERR); end
        n_cmp++; if (bus.RF_WrEn !== 1'b0) begin n_err++; $display("FAIL rm_discard_wren got %b want 0", bus.RF_WrEn); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write();
        test_read_alu();
        test_alu_ops();
        test_abort();
        test_timeout();
        test_byte_wins_timeout();
        test_simultaneous();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
